// File: rtl/playlist_tone_sequencer_pkg.sv
// rtl/playlist_tone_sequencer_pkg.sv - shared types, speed codes and duty helper for the tone sequencer
// Purpose: player state enum, speed code constants, duty width and quarter-step duty helper.
// Ports: none (package).
package playlist_tone_sequencer_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      GAP   = 2'd3
   } state_e;

   localparam logic [1:0] SPEED_HALF = 2'b00;
   localparam logic [1:0] SPEED_1X   = 2'b01;
   localparam logic [1:0] SPEED_1P5X = 2'b10;
   localparam logic [1:0] SPEED_2X   = 2'b11;

   localparam int DUTY_W = 10;

   // quality 0..3 selects 1..4 quarters of full-scale duty
   function automatic logic [DUTY_W-1:0] duty_quarter(input logic [1:0] quality, input int duty_max);
      return DUTY_W'((duty_max >> 2) * (int'(quality) + 1));
   endfunction

endpackage

// File: rtl/playlist_tone_sequencer_if.sv
// rtl/playlist_tone_sequencer_if.sv - control, tone ROM and PWM-bank signals of the tone sequencer
// Purpose: bundles the player controls, tone ROM address/data and PWM bank outputs.
// Ports: master = controller/ROM side (drives controls and ROM data), slave = sequencer.
interface playlist_tone_sequencer_if #(
   parameter int SONG_W = 2,
   parameter int NUM_CH = 2,
   parameter int FREQ_W = 32,
   parameter int BEAT_W = 8,
   parameter int DUTY_W = playlist_tone_sequencer_pkg::DUTY_W
);
   logic                     play_pause;
   logic                     next;
   logic                     prev;
   logic                     song_load;
   logic [SONG_W-1:0]        song_sel;
   logic                     repeat_en;
   logic                     mute;
   logic [1:0]               speed;
   logic [1:0]               quality;
   logic [SONG_W-1:0]        rom_song;
   logic [BEAT_W-1:0]        rom_beat;
   logic [NUM_CH*FREQ_W-1:0] rom_tone;
   logic                     rom_last;
   logic [NUM_CH*FREQ_W-1:0] tone_freq;
   logic [DUTY_W-1:0]        tone_duty;
   logic [NUM_CH-1:0]        amp_en;
   logic                     song_finished;
   logic                     playing;

   modport master (
      output play_pause, next, prev, song_load, song_sel, repeat_en, mute, speed, quality,
      output rom_tone, rom_last,
      input  rom_song, rom_beat, tone_freq, tone_duty, amp_en, song_finished, playing
   );

   modport slave (
      input  play_pause, next, prev, song_load, song_sel, repeat_en, mute, speed, quality,
      input  rom_tone, rom_last,
      output rom_song, rom_beat, tone_freq, tone_duty, amp_en, song_finished, playing
   );
endinterface

// File: rtl/playlist_tone_sequencer_beat_tick_gen.sv
// rtl/playlist_tone_sequencer_beat_tick_gen.sv - phase accumulator beat tick generator with speed scaling
// Purpose: accumulates a speed-scaled increment; the accumulator carry is the beat tick.
// Ports: clk, reset (async high); run advances the accumulator, clear zeroes it (wins over run);
//        speed selects 0.5x/1x/1.5x/2x; tick is combinational, high in the cycle the carry occurs.
module playlist_tone_sequencer_beat_tick_gen
   import playlist_tone_sequencer_pkg::*;
#(
   parameter int ACC_W    = 32,
   parameter int BEAT_INC = 344
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] speed,
   output logic       tick
);
   localparam logic [ACC_W:0] INC_1X = (ACC_W+1)'(BEAT_INC);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   inc;
   logic [ACC_W:0]   sum;

   always_comb begin
      inc = INC_1X;
      case (speed)
         SPEED_HALF: inc = INC_1X >> 1;
         SPEED_1X:   inc = INC_1X;
         SPEED_1P5X: inc = INC_1X + (INC_1X >> 1);
         SPEED_2X:   inc = INC_1X << 1;
         default:    inc = INC_1X;
      endcase
   end

   // one extra bit so the wrap of the accumulator shows up as the carry
   assign sum  = {1'b0, acc} + inc;
   assign tick = run & sum[ACC_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (run) begin
         acc <= sum[ACC_W-1:0];
      end
   end
endmodule

// File: rtl/playlist_tone_sequencer.sv
// rtl/playlist_tone_sequencer.sv - playlist sequencer stepping a tone ROM and driving the PWM bank
// Purpose: play/pause/next/prev/load/repeat playlist control, beat stepping through an external tone ROM,
//          registered tone frequency, duty and amplifier enables. Optional inter-song silence when
//          PLAYLIST_GAP_EN is defined (GAP_BEATS silent beats after an automatic song advance).
// Ports: clk, reset (async high); bus (slave modport): controls in, ROM address out / ROM data in,
//        tone_freq/tone_duty/amp_en/song_finished/playing out.
module playlist_tone_sequencer
   import playlist_tone_sequencer_pkg::*;
#(
   parameter int NUM_SONGS = 4,
   parameter int NUM_CH    = 2,
   parameter int FREQ_W    = 32,
   parameter int BEAT_W    = 8,
   parameter int ACC_W     = 32,
   parameter int BEAT_INC  = 344,
   parameter int DUTY_MAX  = 512
`ifdef PLAYLIST_GAP_EN
   ,parameter int GAP_BEATS = 4
`endif
) (
   input  logic clk,
   input  logic reset,
   playlist_tone_sequencer_if.slave bus
);
   localparam int SONG_W = $clog2(NUM_SONGS);
   localparam logic [SONG_W:0]   NUM_SONGS_V = (SONG_W+1)'(NUM_SONGS);
   localparam logic [SONG_W-1:0] LAST_SONG   = SONG_W'(NUM_SONGS - 1);

   state_e            state, state_n;
   logic [SONG_W-1:0] song, song_n, song_inc, song_dec;
   logic [BEAT_W-1:0] beat, beat_n;
   logic              fin_n;
   logic              acc_clear;
   logic              tick;
   logic              run;
   logic              end_of_song;
   logic              load_ok;

`ifdef PLAYLIST_GAP_EN
   localparam int GAP_CNT_W = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_BEATS - 1);
   logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_n;
   logic                 gap_resume, gap_resume_n;   // PAUSE was entered from (or into) GAP
`endif

   assign run      = (state == PLAY) || (state == GAP);
   assign song_inc = (song == LAST_SONG) ? '0 : song + 1'b1;
   assign song_dec = (song == '0) ? LAST_SONG : song - 1'b1;
   assign load_ok  = {1'b0, bus.song_sel} < NUM_SONGS_V;

   playlist_tone_sequencer_beat_tick_gen #(
      .ACC_W    (ACC_W),
      .BEAT_INC (BEAT_INC)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clear (acc_clear),
      .speed (bus.speed),
      .tick  (tick)
   );

   always_comb begin
      state_n     = state;
      song_n      = song;
      beat_n      = beat;
      fin_n       = 1'b0;
      acc_clear   = 1'b0;
      end_of_song = bus.rom_last || (beat == '1);
`ifdef PLAYLIST_GAP_EN
      gap_cnt_n    = gap_cnt;
      gap_resume_n = gap_resume;
`endif

      // song selection: load > next > prev > beat tick
      if ((bus.song_load && load_ok) || bus.next || bus.prev) begin
         if (bus.song_load && load_ok) begin
            song_n = bus.song_sel;
         end else if (bus.next) begin
            song_n = song_inc;
         end else begin
            song_n = song_dec;
         end
         beat_n    = '0;
         acc_clear = 1'b1;
`ifdef PLAYLIST_GAP_EN
         // a manual song change abandons any pending silence
         if (state == GAP) begin
            state_n = PLAY;
         end
         gap_resume_n = 1'b0;
`endif
      end else if (tick && state == PLAY) begin
         if (end_of_song) begin
            fin_n  = 1'b1;
            beat_n = '0;
            if (!bus.repeat_en) begin
               song_n    = song_inc;
               acc_clear = 1'b1;
`ifdef PLAYLIST_GAP_EN
               state_n   = GAP;
               gap_cnt_n = '0;
`endif
            end
         end else begin
            beat_n = beat + 1'b1;
         end
      end
`ifdef PLAYLIST_GAP_EN
      else if (tick && state == GAP) begin
         if (gap_cnt == GAP_LAST) begin
            state_n = PLAY;
         end else begin
            gap_cnt_n = gap_cnt + 1'b1;
         end
      end
`endif

      // play_pause combines with whatever song change happened above
      if (bus.play_pause) begin
         case (state)
            STOP:  state_n = PLAY;
            PLAY, GAP: begin
`ifdef PLAYLIST_GAP_EN
               gap_resume_n = (state_n == GAP);
`endif
               state_n = PAUSE;
            end
            PAUSE: begin
`ifdef PLAYLIST_GAP_EN
               state_n = gap_resume_n ? GAP : PLAY;
`else
               state_n = PLAY;
`endif
            end
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= STOP;
         song  <= '0;
         beat  <= '0;
`ifdef PLAYLIST_GAP_EN
         gap_cnt    <= '0;
         gap_resume <= 1'b0;
`endif
      end else begin
         state <= state_n;
         song  <= song_n;
         beat  <= beat_n;
`ifdef PLAYLIST_GAP_EN
         gap_cnt    <= gap_cnt_n;
         gap_resume <= gap_resume_n;
`endif
      end
   end

   // ROM data is for the current song/beat, so outputs trail a beat change by one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.tone_freq     <= '0;
         bus.tone_duty     <= '0;
         bus.amp_en        <= '0;
         bus.song_finished <= 1'b0;
      end else begin
         bus.tone_freq     <= (state == PLAY || state == PAUSE) ? bus.rom_tone : '0;
         bus.amp_en        <= (state == PLAY && !bus.mute) ? '1 : '0;
         bus.tone_duty     <= duty_quarter(bus.quality, DUTY_MAX);
         bus.song_finished <= fin_n;
      end
   end

   assign bus.rom_song = song;
   assign bus.rom_beat = beat;
   assign bus.playing  = (state == PLAY);
endmodule

// File: tb/tb_playlist_tone_sequencer.sv
// tb/tb_playlist_tone_sequencer.sv - scoreboard bench for playlist_tone_sequencer
module tb_playlist_tone_sequencer;
   localparam int NUM_SONGS = 3;
   localparam int SONG_W    = 2;
   localparam int NUM_CH    = 2;
   localparam int FREQ_W    = 32;
   localparam int BEAT_W    = 8;
   localparam int ACC_W     = 8;
   localparam int BEAT_INC  = 64;
   localparam int DUTY_MAX  = 512;
   localparam int GAP_N     = 4;
   localparam int S_STOP = 0, S_PLAY = 1, S_PAUSE = 2, S_GAP = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   playlist_tone_sequencer_if #(.SONG_W(SONG_W), .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .BEAT_W(BEAT_W)) bus ();

   playlist_tone_sequencer #(
      .NUM_SONGS (NUM_SONGS), .NUM_CH (NUM_CH), .FREQ_W (FREQ_W), .BEAT_W (BEAT_W),
      .ACC_W (ACC_W), .BEAT_INC (BEAT_INC), .DUTY_MAX (DUTY_MAX)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] rom_word(input int s, input int b, input int ch);
      return 32'(32'h1000 + s * 256 + b * 16 + ch);
   endfunction

   // every song is three beats long
   assign bus.rom_tone = {rom_word(int'(bus.rom_song), int'(bus.rom_beat), 1),
                          rom_word(int'(bus.rom_song), int'(bus.rom_beat), 0)};
   assign bus.rom_last = (bus.rom_beat == 8'd2);

   typedef struct {
      logic [1:0]  song;
      logic [7:0]  beat;
      logic [63:0] tone;
      logic [1:0]  amp;
      logic [9:0]  duty;
      logic        playing;
      logic        fin;
   } exp_t;

   exp_t out_q[$];
   int   fin_q[$];
   int   tests = 0;
   int   fails = 0;

   int m_st, m_song, m_beat, m_phase, m_gapres, m_gapleft;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int inc_for(input int sp);
      case (sp)
         0: return BEAT_INC / 2;
         1: return BEAT_INC;
         2: return (BEAT_INC * 3) / 2;
         default: return BEAT_INC * 2;
      endcase
   endfunction

   task automatic model_reset();
      m_st = S_STOP; m_song = 0; m_beat = 0; m_phase = 0; m_gapres = 0; m_gapleft = 0;
      out_q.delete();
      fin_q.delete();
   endtask

   task automatic song_changed();
      m_beat = 0; m_phase = 0; m_gapres = 0;
      if (m_st == S_GAP) m_st = S_PLAY;
   endtask

   // one clock of player behaviour, evaluated at the active edge with the inputs then applied
   task automatic model_step();
      int   o_st, o_song, o_beat;
      bit   tick, fin;
      exp_t e;
      o_st = m_st; o_song = m_song; o_beat = m_beat;
      tick = 0; fin = 0;
      if (o_st == S_PLAY || o_st == S_GAP) begin
         m_phase += inc_for(int'(bus.speed));
         if (m_phase >= 256) begin
            tick = 1;
            m_phase -= 256;
         end
      end
      if (bus.song_load && int'(bus.song_sel) < NUM_SONGS) begin
         m_song = int'(bus.song_sel); song_changed();
      end else if (bus.next) begin
         m_song = (m_song + 1) % NUM_SONGS; song_changed();
      end else if (bus.prev) begin
         m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS; song_changed();
      end else if (tick && o_st == S_PLAY) begin
         if (o_beat == 2 || o_beat == 255) begin
            fin = 1;
            m_beat = 0;
            if (!bus.repeat_en) begin
               m_song = (m_song + 1) % NUM_SONGS;
               m_phase = 0;
`ifdef PLAYLIST_GAP_EN
               m_st = S_GAP;
               m_gapleft = GAP_N;
`endif
            end
         end else begin
            m_beat++;
         end
      end else if (tick && o_st == S_GAP) begin
         m_gapleft--;
         if (m_gapleft == 0) m_st = S_PLAY;
      end
      if (bus.play_pause) begin
         if (o_st == S_STOP) m_st = S_PLAY;
         else if (o_st == S_PLAY || o_st == S_GAP) begin
            m_gapres = (m_st == S_GAP);
            m_st = S_PAUSE;
         end else m_st = m_gapres ? S_GAP : S_PLAY;
      end
      e.song    = 2'(m_song);
      e.beat    = 8'(m_beat);
      e.tone    = (o_st == S_PLAY || o_st == S_PAUSE) ?
                  {rom_word(o_song, o_beat, 1), rom_word(o_song, o_beat, 0)} : 64'd0;
      e.amp     = (o_st == S_PLAY && !bus.mute) ? 2'b11 : 2'b00;
      e.duty    = 10'((DUTY_MAX / 4) * (int'(bus.quality) + 1));
      e.playing = (m_st == S_PLAY);
      e.fin     = fin;
      out_q.push_back(e);
      if (fin) fin_q.push_back(m_song);
   endtask

   // monitor: registered outputs are presented every cycle; song_finished is an event
   exp_t mon_e;
   always @(negedge clk) begin
      if (!reset && out_q.size() > 0) begin
         mon_e = out_q.pop_front();
         check("rom_song", 64'(bus.rom_song), 64'(mon_e.song));
         check("rom_beat", 64'(bus.rom_beat), 64'(mon_e.beat));
         check("tone_freq", bus.tone_freq, mon_e.tone);
         check("amp_en", 64'(bus.amp_en), 64'(mon_e.amp));
         check("tone_duty", 64'(bus.tone_duty), 64'(mon_e.duty));
         check("playing", 64'(bus.playing), 64'(mon_e.playing));
         check("song_finished", 64'(bus.song_finished), 64'(mon_e.fin));
      end
      if (!reset && bus.song_finished) begin
         if (fin_q.size() == 0) check("finish_unexpected", 64'(bus.song_finished), 64'd0);
         else check("finish_next_song", 64'(bus.rom_song), 64'(fin_q.pop_front()));
      end
   end

   task automatic cyc(input bit pp, input bit nx, input bit pv, input bit ld, input logic [1:0] sel);
      bus.play_pause = pp;
      bus.next       = nx;
      bus.prev       = pv;
      bus.song_load  = ld;
      bus.song_sel   = sel;
      @(posedge clk);
      if (!reset) model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 2'd0);
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check("rst_playing", 64'(bus.playing), 64'd0);
      check("rst_rom_song", 64'(bus.rom_song), 64'd0);
      check("rst_rom_beat", 64'(bus.rom_beat), 64'd0);
      check("rst_tone_freq", bus.tone_freq, 64'd0);
      check("rst_tone_duty", 64'(bus.tone_duty), 64'd0);
      check("rst_amp_en", 64'(bus.amp_en), 64'd0);
      check("rst_song_finished", 64'(bus.song_finished), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      check_reset_state();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bus.play_pause = 0; bus.next = 0; bus.prev = 0; bus.song_load = 0; bus.song_sel = 0;
      bus.repeat_en = 0; bus.mute = 0; bus.speed = 2'b01; bus.quality = 2'd0;
      do_reset();

      // start playing at 1x and walk through two songs
      cyc(1, 0, 0, 0, 2'd0);
      idle(30);
      // load beats next in the same cycle
      cyc(0, 1, 0, 1, 2'd2);
      idle(5);
      cyc(0, 0, 1, 0, 2'd0);
      cyc(0, 0, 1, 0, 2'd0);
      cyc(0, 0, 1, 0, 2'd0);     // prev from song 0 wraps to the last song
      idle(3);
      cyc(0, 0, 0, 1, 2'd3);     // out-of-range select ignored
      idle(3);
      bus.repeat_en = 1; bus.quality = 2'd3;
      idle(30);
      bus.repeat_en = 0;
      bus.speed = 2'b11;
      idle(20);
      bus.speed = 2'b00;
      idle(13);
      cyc(1, 0, 0, 0, 2'd0);     // pause mid-beat
      idle(10);
      cyc(1, 0, 0, 0, 2'd0);     // resume
      idle(20);
      bus.mute = 1; bus.speed = 2'b10;
      idle(10);
      bus.mute = 0;
      idle(10);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) bus.repeat_en = ~bus.repeat_en;
         if ($urandom_range(0, 49) == 0) bus.mute = ~bus.mute;
         if ($urandom_range(0, 79) == 0) bus.speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) bus.quality = 2'($urandom_range(0, 3));
         if (i == 1500) do_reset();
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 69) == 0, $urandom_range(0, 69) == 0,
             $urandom_range(0, 69) == 0, 2'($urandom_range(0, 3)));
      end
      idle(4);
      @(negedge clk);
      #1;
      check("out_queue_drained", 64'(out_q.size()), 64'd0);
      check("finish_queue_drained", 64'(fin_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
